// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
//   Sequencer for one convolution layer. It steps a KERNEL_DIM x KERNEL_DIM
//   window over the input feature map with a configurable stride and zero
//   padding. For each window it writes NUM_ADDR ibuf words into the CIM input
//   registers, fires the CIM, waits for the result and then hands it to the
//   function stage.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   i_start         start one full layer pass (only honoured in IDLE)
//   o_ready         high only in IDLE
//   o_win_row/col   signed top-left window coordinate (idx*STRIDE-PADDING)
//   o_addr          ibuf/CIM word address
//   o_cim_we        CIM input-register write strobe
//   o_cim_start     one-cycle CIM compute pulse
//   i_cim_ready     CIM idle / result available
//   i_func_ready    function stage can accept a result
//   o_func_start    one-cycle function-stage start pulse
//   o_done          one-cycle pulse after the last window
module conv_window_ctrl #(
  parameter int IMG_DIM        = 28,
  parameter int KERNEL_DIM     = 3,
  parameter int INPUT_CHANNELS = 2,
  parameter int XBAR_SIZE      = 128,
  parameter int BUS_WIDTH      = 16,
  parameter int STRIDE         = 1,
  parameter int PADDING        = 0,
  localparam int OUT_DIM     = (IMG_DIM + 2*PADDING - KERNEL_DIM) / STRIDE + 1,
  localparam int TAPS        = INPUT_CHANNELS * KERNEL_DIM * KERNEL_DIM,
  localparam int V_CIM_TILES = (TAPS + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int NA_RAW      = (TAPS + BUS_WIDTH*V_CIM_TILES - 1) / (BUS_WIDTH*V_CIM_TILES),
  localparam int NUM_ADDR    = (NA_RAW < 1) ? 1 : NA_RAW,
  localparam int ADDR_WIDTH  = (NUM_ADDR <= 1) ? 1 : $clog2(NUM_ADDR),
  localparam int CW          = $clog2(IMG_DIM + PADDING) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_ready,
  output logic signed [CW-1:0]  o_win_row,
  output logic signed [CW-1:0]  o_win_col,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_cim_we,
  output logic                  o_cim_start,
  input  logic                  i_cim_ready,
  input  logic                  i_func_ready,
  output logic                  o_func_start,
  output logic                  o_done
);

  localparam int CNT_W = (OUT_DIM <= 1) ? 1 : $clog2(OUT_DIM);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_ADDR - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(OUT_DIM - 1);

  typedef enum logic [2:0] {
    IDLE, WRITE, CIM_START, CIM_WAIT, FUNC, DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        row_q, row_d, col_q, col_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  // High in the first CIM_WAIT cycle: the CIM ready line may still show the
  // previous idle level right after the start pulse, so it is not trusted yet.
  logic                    blank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      blank_q <= (state_q == CIM_START);
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    o_func_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          state_d = CIM_START;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      CIM_START: state_d = CIM_WAIT;
      CIM_WAIT: begin
        if (!blank_q && i_cim_ready) state_d = FUNC;
      end
      FUNC: begin
        if (i_func_ready) begin
          o_func_start = 1'b1;
          state_d      = WRITE;
          if (col_q != CNT_LAST) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            if (row_q == CNT_LAST) begin
              // Last window: park counters at the origin for the next pass.
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Coordinates are computed one bit wider so the padding subtraction cannot
  // wrap before the final truncation.
  logic signed [CW:0] row_full, col_full;
  assign row_full = $signed((CW+1)'(row_q)) * $signed((CW+1)'(STRIDE))
                  - $signed((CW+1)'(PADDING));
  assign col_full = $signed((CW+1)'(col_q)) * $signed((CW+1)'(STRIDE))
                  - $signed((CW+1)'(PADDING));

  assign o_win_row   = row_full[CW-1:0];
  assign o_win_col   = col_full[CW-1:0];
  assign o_addr      = addr_q;
  assign o_ready     = (state_q == IDLE);
  assign o_cim_we    = (state_q == WRITE);
  assign o_cim_start = (state_q == CIM_START);
  assign o_done      = (state_q == DONE);

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: three instances (default, STRIDE=2,
// PADDING=1) share the control inputs; a negedge monitor checks window
// sequencing during a full pass, then backpressure and mid-pass reset are
// exercised on the default instance.
module tb_conv_window_ctrl;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic i_cim_ready = 1'b1;
  logic i_func_ready = 1'b1;

  always #5 clk = ~clk;

  logic d0_ready, d0_we, d0_cs, d0_fs, d0_done;
  logic d1_ready, d1_we, d1_cs, d1_fs, d1_done;
  logic d2_ready, d2_we, d2_cs, d2_fs, d2_done;
  logic [0:0] d0_addr, d1_addr, d2_addr;
  logic signed [CW-1:0] d0_row, d0_col, d1_row, d1_col, d2_row, d2_col;

  conv_window_ctrl u0 (
    .clk(clk), .rst(rst), .i_start(i_start), .o_ready(d0_ready),
    .o_win_row(d0_row), .o_win_col(d0_col), .o_addr(d0_addr),
    .o_cim_we(d0_we), .o_cim_start(d0_cs), .i_cim_ready(i_cim_ready),
    .i_func_ready(i_func_ready), .o_func_start(d0_fs), .o_done(d0_done));

  conv_window_ctrl #(.STRIDE(2)) u1 (
    .clk(clk), .rst(rst), .i_start(i_start), .o_ready(d1_ready),
    .o_win_row(d1_row), .o_win_col(d1_col), .o_addr(d1_addr),
    .o_cim_we(d1_we), .o_cim_start(d1_cs), .i_cim_ready(i_cim_ready),
    .i_func_ready(i_func_ready), .o_func_start(d1_fs), .o_done(d1_done));

  conv_window_ctrl #(.PADDING(1)) u2 (
    .clk(clk), .rst(rst), .i_start(i_start), .o_ready(d2_ready),
    .o_win_row(d2_row), .o_win_col(d2_col), .o_addr(d2_addr),
    .o_cim_we(d2_we), .o_cim_start(d2_cs), .i_cim_ready(i_cim_ready),
    .i_func_ready(i_func_ready), .o_func_start(d2_fs), .o_done(d2_done));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon_en = 1'b0;
  bit done0_prev = 1'b0;
  int t_start = 0;
  int n_cs0 = 0, n_fs0 = 0, n_done0 = 0, n_we0 = 0, last_fs0 = 0;
  int k1 = 0, k2 = 0, n_done1 = 0, n_done2 = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (done0_prev) chk("ready_after_done", d0_ready, 1);
      done0_prev = d0_done;
      if (d0_we) begin
        chk("addr_seq", d0_addr, n_we0 % 2);
        n_we0++;
      end
      if (d0_cs) n_cs0++;
      if (d0_fs) begin
        if (n_fs0 == 0) chk("first_func_lat", cyc - t_start, 6);
        else            chk("window_period", cyc - last_fs0, 6);
        chk("ready_busy", d0_ready, 0);
        last_fs0 = cyc;
        n_fs0++;
      end
      if (d0_done) begin
        chk("done_lat", cyc - last_fs0, 1);
        chk("ready_in_done", d0_ready, 0);
        n_done0++;
      end
      if (d1_fs) begin
        chk("s2_row", d1_row, (k1 / 13) * 2);
        chk("s2_col", d1_col, (k1 % 13) * 2);
        k1++;
      end
      if (d1_done) n_done1++;
      if (d2_fs) begin
        chk("p1_row", d2_row, k2 / 28 - 1);
        chk("p1_col", d2_col, k2 % 28 - 1);
        k2++;
      end
      if (d2_done) n_done2++;
    end
  end

  initial begin
    bit seen;
    bit all_done;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", d0_ready, 1);
    chk("rst_strobes", {d0_we, d0_cs, d0_fs, d0_done}, 0);
    chk("rst_addr", d0_addr, 0);
    chk("rst_row", d0_row, 0);
    chk("rst_col", d0_col, 0);
    chk("rst_pad_row", d2_row, -1);
    chk("rst_pad_col", d2_col, -1);
    chk("rst_s2_row", d1_row, 0);
    rst = 1'b0;

    // Full pass with ready inputs high, plus ignored starts while busy
    mon_en = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (6) @(posedge clk);
    #1 i_start = 1'b1;          // window 1, first WRITE cycle
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_start = 1'b1;          // window 1, first CIM_WAIT cycle
    @(posedge clk); #1;
    i_start = 1'b0;

    all_done = 1'b0;
    for (int i = 0; i < 6000 && !all_done; i++) begin
      @(posedge clk);
      all_done = (n_done0 > 0) && (n_done1 > 0) && (n_done2 > 0);
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("pass_timeout", all_done, 1);
    chk("cim_start_cnt", n_cs0, 676);
    chk("func_start_cnt", n_fs0, 676);
    chk("addr_writes", n_we0, 1352);
    chk("done_cnt", n_done0, 1);
    chk("s2_windows", k1, 169);
    chk("s2_done_cnt", n_done1, 1);
    chk("p1_windows", k2, 784);
    chk("p1_done_cnt", n_done2, 1);
    chk("idle_after_pass", d0_ready, 1);

    // Backpressure
    @(posedge clk); #1;
    i_cim_ready  = 1'b0;
    i_func_ready = 1'b0;
    i_start      = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = d0_cs;
    end
    chk("bp_cs_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_cim_quiet", {d0_we, d0_cs, d0_fs, d0_done}, 0);
    end
    i_cim_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_func_quiet", {d0_we, d0_cs, d0_fs, d0_done}, 0);
      chk("bp_busy", d0_ready, 0);
    end
    i_func_ready = 1'b1;
    #1 chk("bp_func_start", d0_fs, 1);
    @(negedge clk);
    chk("bp_next_we", d0_we, 1);
    chk("bp_next_addr", d0_addr, 0);
    chk("bp_next_col", d0_col, 1);

    // Reset during CIM_WAIT of window 5
    repeat (27) @(negedge clk);
    chk("w5_col", d0_col, 5);
    chk("w5_in_wait", {d0_we, d0_cs, d0_fs}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", d0_ready, 1);
    chk("mid_rst_strobes", {d0_we, d0_cs, d0_fs, d0_done}, 0);
    chk("mid_rst_addr", d0_addr, 0);
    chk("mid_rst_col", d0_col, 0);
    chk("mid_rst_pad_row", d2_row, -1);
    chk("mid_rst_pad_col", d2_col, -1);
    rst = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("restart_we", d0_we, 1);
    chk("restart_addr0", d0_addr, 0);
    chk("restart_row", d0_row, 0);
    chk("restart_col", d0_col, 0);
    chk("restart_pad_row", d2_row, -1);
    chk("restart_pad_col", d2_col, -1);
    @(negedge clk);
    chk("restart_addr1", d0_addr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
